// File: rtl/gpio_in_filter.sv
// Per-pin glitch filter with a shared programmable length, sticky edge
// flags and a registered change pulse. All outputs come straight from flops.
module gpio_in_filter #(
  parameter int unsigned IOWidth   = 36,
  parameter int unsigned FiltWidth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IOWidth-1:0]   read_data,
  input  logic [FiltWidth-1:0] filt_len,
  input  logic [IOWidth-1:0]   filt_en,
  input  logic [IOWidth-1:0]   clr_rise,
  input  logic [IOWidth-1:0]   clr_fall,
  output logic [IOWidth-1:0]   filt_data,
  output logic [IOWidth-1:0]   rise_sticky,
  output logic [IOWidth-1:0]   fall_sticky,
  output logic [IOWidth-1:0]   change_pulse
);

  logic [FiltWidth-1:0] cnt_q [IOWidth];
  logic [FiltWidth-1:0] cnt_d [IOWidth];
  logic [IOWidth-1:0]   filt_q, filt_d;
  logic [IOWidth-1:0]   rise_q, rise_d;
  logic [IOWidth-1:0]   fall_q, fall_d;
  logic [IOWidth-1:0]   upd_q,  upd_d;
  logic [IOWidth-1:0]   chg_q;

  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < IOWidth; i++) begin
      cnt_d[i] = '0;
      if (!filt_en[i]) begin
        filt_d[i] = read_data[i];
      end else if (read_data[i] != filt_q[i]) begin
        // >= lets a lowered filt_len take effect on a count already past it
        if (cnt_q[i] >= filt_len) begin
          filt_d[i] = read_data[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    upd_d  = filt_d ^ filt_q;
    rise_d = (rise_q & ~clr_rise) | (upd_d & filt_d);
    fall_d = (fall_q & ~clr_fall) | (upd_d & ~filt_d);
  end

  // change_pulse trails the update edge by one cycle via upd_q
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < IOWidth; i++) begin
        cnt_q[i] <= '0;
      end
      filt_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      upd_q  <= '0;
      chg_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < IOWidth; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      upd_q  <= upd_d;
      chg_q  <= upd_q;
    end
  end

  assign filt_data    = filt_q;
  assign rise_sticky  = rise_q;
  assign fall_sticky  = fall_q;
  assign change_pulse = chg_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter: a vector table for the single-cycle
// behaviour plus hand sequences for threshold, sticky race, len change and reset.
module tb_gpio_in_filter;

  localparam logic [35:0] A = 36'hF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [35:0] rd, en, cr, cf;
  logic [7:0]  len;
  logic [35:0] filt_data, rise_sticky, fall_sticky, change_pulse;

  int total = 0;
  int bad   = 0;

  gpio_in_filter #(.IOWidth(36), .FiltWidth(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .read_data    (rd),
    .filt_len     (len),
    .filt_en      (en),
    .clr_rise     (cr),
    .clr_fall     (cf),
    .filt_data    (filt_data),
    .rise_sticky  (rise_sticky),
    .fall_sticky  (fall_sticky),
    .change_pulse (change_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] en;
    logic [7:0]  len;
    logic [35:0] rd, cr, cf;
    logic [35:0] ef, er, efl, ec;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [35:0] e, input logic [7:0] l, input logic [35:0] r,
                     input logic [35:0] c_r, input logic [35:0] c_f,
                     input logic [35:0] ef, input logic [35:0] er,
                     input logic [35:0] efl, input logic [35:0] ec);
    vec_t v;
    v.en = e; v.len = l; v.rd = r; v.cr = c_r; v.cf = c_f;
    v.ef = ef; v.er = er; v.efl = efl; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    steps(2);
    check("reset filt", filt_data, '0);
    check("reset rise", rise_sticky, '0);
    check("reset fall", fall_sticky, '0);
    check("reset chg", change_pulse, '0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rd = '0; en = '0; cr = '0; cf = '0; len = '0;

    //  en        len rd  cr  cf   filt rise fall chg
    add('0,       0,  1,  0,  0,   1,   1,   0,   0);
    add('0,       0,  1,  0,  0,   1,   1,   0,   1);
    add('0,       0,  1,  0,  0,   1,   1,   0,   0);
    add('0,       0,  0,  0,  0,   0,   1,   1,   0);
    add('0,       0,  0,  1,  0,   0,   0,   1,   1);
    add('0,       0,  0,  0,  1,   0,   0,   0,   0);
    add(A,        2,  2,  0,  0,   0,   0,   0,   0);
    add(A,        2,  2,  0,  0,   0,   0,   0,   0);
    add(A,        2,  2,  0,  0,   2,   2,   0,   0);
    add(A,        2,  2,  0,  0,   2,   2,   0,   2);
    add(A,        2,  2,  0,  0,   2,   2,   0,   0);
    add(A,        2,  0,  0,  0,   2,   2,   0,   0);
    add(A,        2,  2,  0,  0,   2,   2,   0,   0);
    add(A,        2,  0,  0,  0,   2,   2,   0,   0);
    add(A,        2,  0,  0,  0,   2,   2,   0,   0);
    add(A,        2,  2,  0,  0,   2,   2,   0,   0);
    add(A,        2,  0,  0,  0,   2,   2,   0,   0);
    add(A,        2,  0,  0,  0,   2,   2,   0,   0);
    add(A,        2,  0,  0,  0,   0,   2,   2,   0);
    add(A,        2,  0,  0,  0,   0,   2,   2,   2);
    add(A,        2,  0,  0,  0,   0,   2,   2,   0);
    add(A,        0,  4,  0,  0,   4,   6,   2,   0);
    add(A,        0,  4,  2,  2,   4,   4,   0,   4);
    add(A,        3,  0,  0,  0,   4,   4,   0,   0);
    add(A & ~36'h4, 3, 0, 0,  0,   0,   4,   4,   0);
    add(A,        3,  0,  0,  0,   0,   4,   4,   4);

    do_reset();
    foreach (vecs[i]) begin
      en = vecs[i].en; len = vecs[i].len; rd = vecs[i].rd;
      cr = vecs[i].cr; cf = vecs[i].cf;
      step();
      check($sformatf("v%0d filt", i), filt_data, vecs[i].ef);
      check($sformatf("v%0d rise", i), rise_sticky, vecs[i].er);
      check($sformatf("v%0d fall", i), fall_sticky, vecs[i].efl);
      check($sformatf("v%0d chg", i), change_pulse, vecs[i].ec);
    end
    cr = '0; cf = '0;

    // Glitch rejection and threshold on pin 3, filt_len=4
    rd = '0; en = A; len = 8'd4;
    do_reset();
    rd = 36'h8;
    for (int k = 0; k < 4; k++) begin
      step();
      check("glitch filt", filt_data, '0);
    end
    rd = '0;
    steps(2);
    check("glitch rise", rise_sticky, '0);
    check("glitch chg", change_pulse, '0);
    rd = 36'h8;
    steps(4);
    check("thr pre filt", filt_data, '0);
    step();
    check("thr rise filt", filt_data, 36'h8);
    check("thr rise sticky", rise_sticky, 36'h8);
    rd = '0;
    steps(4);
    check("thr pre fall", filt_data, 36'h8);
    step();
    check("thr fall filt", filt_data, '0);
    check("thr fall sticky", fall_sticky, 36'h8);

    // Sticky set/clear race on pin 5
    cr = A; cf = A; len = '0;
    step();
    cr = '0; cf = '0;
    check("clr all rise", rise_sticky, '0);
    rd = 36'h20;
    step();
    check("race rise1", rise_sticky, 36'h20);
    rd = '0;
    step();
    check("race fall", fall_sticky, 36'h20);
    rd = 36'h20; cr = 36'h20;
    step();
    check("race set wins", rise_sticky, 36'h20);
    cr = 36'h20;
    step();
    cr = '0;
    check("race clear", rise_sticky, '0);

    // filt_len lowered mid-count on pin 7
    len = 8'd200; rd = 36'ha0;
    steps(50);
    check("len200 hold", filt_data[7], 1'b0);
    len = 8'd10;
    step();
    check("len drop update", filt_data[7], 1'b1);

    // Reset mid-count on pin 1
    rd = '0; len = '0;
    steps(2);
    len = 8'd8; rd = 36'h2;
    steps(5);
    reset = 1'b1;
    step();
    check("midrst filt", filt_data, '0);
    reset = 1'b0;
    steps(8);
    check("midrst pre", filt_data[1], 1'b0);
    step();
    check("midrst update", filt_data[1], 1'b1);

    // Enable toggle mid-count on pin 9
    len = 8'd10; rd = 36'h202;
    steps(3);
    check("tog counting", filt_data[9], 1'b0);
    en = A & ~36'h200;
    step();
    check("tog bypass", filt_data[9], 1'b1);
    en = A; rd = 36'h2;
    steps(10);
    check("tog restart pre", filt_data[9], 1'b1);
    step();
    check("tog restart upd", filt_data[9], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_in_filter.md
Name: gpio_in_filter

Overview:
- Per-pin digital glitch filter with edge capture, sitting directly downstream of the bidirectional I/O stage.
- Consumes the registered pin samples (read_data) from that stage.
- Produces debounced levels, sticky rise/fall flags and a one-cycle change pulse for the register file and encoder/counter logic.
- All pins share one programmable filter length; filtering is enabled per pin.

Parameters:
- IOWidth, 36, number of pins handled.
- FiltWidth, 8, width of the filter-length value and of each per-pin counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- read_data  input  IOWidth  raw pin samples from the I/O stage, already registered to clk.
- filt_len  input  FiltWidth  shared filter length N.
- filt_en  input  IOWidth  per-pin enable: 1 = filtered, 0 = bypass.
- clr_rise  input  IOWidth  write-1-to-clear strobe for rise_sticky.
- clr_fall  input  IOWidth  write-1-to-clear strobe for fall_sticky.
- filt_data  output  IOWidth  debounced pin level.
- rise_sticky  output  IOWidth  latched 0->1 transition of filt_data.
- fall_sticky  output  IOWidth  latched 1->0 transition of filt_data.
- change_pulse  output  IOWidth  one-cycle pulse on any filt_data transition.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: filt_data 0, rise_sticky 0, fall_sticky 0, change_pulse 0, all counters 0.
- Reset mid-operation discards any in-progress count on the next edge.
- Each pin i is independent; it holds a counter cnt[i] of width FiltWidth.
- Define diff = (read_data[i] != filt_data[i]).
- Bypass, filt_en[i]=0:
  - filt_data[i] <= read_data[i] every edge (1-cycle latency).
  - cnt[i] <= 0.
- Filtered, filt_en[i]=1:
  - diff=0: cnt[i] <= 0 (any glitch shorter than the threshold is discarded).
  - diff=1 and cnt[i] >= filt_len: filt_data[i] <= read_data[i], cnt[i] <= 0.
  - diff=1 and cnt[i] < filt_len: cnt[i] <= cnt[i]+1.
- Latency: the raw level must differ for N+1 consecutive samples. filt_data changes on the (N+1)th edge after the first differing sample.
- filt_len=0 behaves identically to bypass.
- The >= comparison makes a mid-count reduction of filt_len take effect immediately. The counter never wraps: max count is filt_len <= 2^FiltWidth-1.
- Toggling filt_en mid-count: on switching to bypass, the count is dropped and filt_data follows raw next edge. On switching to filtered, counting starts from 0.
- update[i] = the edge on which filt_data[i] changes value; this covers both bypass and filtered modes.
- change_pulse[i] is registered: high for exactly the one cycle following update[i], low otherwise.
- rise_sticky[i] sets on update[i] with new value 1; fall_sticky[i] sets on update[i] with new value 0.
- Stickies hold until cleared. clr_* clears on the next edge.
- Set and clear asserted on the same edge: set wins.
- After reset, a pin held at 1 produces a normal rise event (filt_data starts at 0); this is not suppressed.
- No combinational path from any input to any output.

Test Plan:
- Reset then bypass: reset=1 for 2 cycles, then filt_en=0, read_data[0] 0->1 at cycle 10 -> filt_data[0]=1 at cycle 11, change_pulse[0]=1 for cycle 12 only, rise_sticky[0]=1 from cycle 11.
- Glitch rejection: filt_en=all 1s, filt_len=4, read_data[3] high for 4 cycles then low -> filt_data[3] stays 0, no change_pulse, no sticky.
- Threshold: filt_len=4, read_data[3] high and held from cycle 20 -> filt_data[3]=1 after edge 25 (5 samples), rise_sticky[3]=1. Then low from cycle 40 -> filt_data[3]=0 after edge 45, fall_sticky[3]=1.
- Sticky clear race: rise_sticky[5]=1, clr_rise[5]=1 on the same edge as a new rise on pin 5 -> rise_sticky[5] remains 1. clr_rise[5] alone on a later edge -> 0 next cycle.
- filt_len change mid-count: filt_len=200, pin 7 differing for 50 cycles, then filt_len set to 10 -> filt_data[7] updates on the next edge.
- Reset mid-count: filt_len=8, pin 1 differing for 5 cycles, reset pulsed 1 cycle, input held -> filt_data[1] updates 9 edges after reset deasserts. Other pins unaffected in behaviour apart from reset values.
